// File: rtl/sram_controller_pkg.sv
// Shared definitions for the SRAM controller: state encodings, default
// geometry and the CPU byte-address to SRAM word-offset mapping.
package sram_controller_pkg;

    typedef enum logic [1:0] {
        SRAM_IDLE   = 2'd0,
        SRAM_ACCESS = 2'd1,
        SRAM_DONE   = 2'd2
    } sram_state_e;

    localparam int          SRAM_DATA_W      = 32;
    localparam int          SRAM_ADDR_W      = 17;
    localparam int          SRAM_WAIT_CYCLES = 5;
    localparam logic [31:0] SRAM_BASE_ADDR   = 32'd1024;

    // Wraps modulo 2^32 on purpose; the caller truncates to the SRAM width.
    function automatic logic [31:0] sram_word_offset(input logic [31:0] byte_addr,
                                                     input logic [31:0] base);
        return (byte_addr - base) >> 2;
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Request/response bundle between the memory stage (master) and the SRAM
// controller (slave).
interface sram_controller_if
    import sram_controller_pkg::*;
#(
    parameter int DATA_W = SRAM_DATA_W
);
    logic              rd_en;
    logic              wr_en;
    logic [31:0]       address;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              ready;

    modport master (
        output rd_en, wr_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  rd_en, wr_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_wait_counter.sv
// Loadable down-counter with a zero flag; paces the SRAM wait states.
module sram_wait_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);
endmodule

// File: rtl/sram_controller.sv
// Turns single-cycle load/store requests into fixed-length SRAM accesses,
// one at a time, and reports completion through ready.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int          DATA_W      = SRAM_DATA_W,
    parameter int          ADDR_W      = SRAM_ADDR_W,
    parameter int          WAIT_CYCLES = SRAM_WAIT_CYCLES,
    parameter logic [31:0] BASE_ADDR   = SRAM_BASE_ADDR
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_controller_if.slave     bus,
    inout  wire  [DATA_W-1:0]    SRAM_DQ,
    output logic [ADDR_W-1:0]    SRAM_ADDR,
    output logic                 SRAM_WE_N
);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    sram_state_e       state_q;
    logic              op_write_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] rdata_q;
    logic              we_n_q;
    logic              oe_q;

    logic              req;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;
    logic [ADDR_W-1:0] word_addr;
    logic              ready_comb;

    assign req       = bus.rd_en | bus.wr_en;
    assign cnt_load  = (state_q == SRAM_IDLE) && req;
    assign cnt_dec   = (state_q == SRAM_ACCESS);
    assign word_addr = ADDR_W'(sram_word_offset(bus.address, BASE_ADDR));

    sram_wait_counter #(
        .WIDTH (CNT_W)
    ) u_wait (
        .clk        (clk),
        .rst_n      (rst),
        .load_i     (cnt_load),
        .dec_i      (cnt_dec),
        .load_val_i (CNT_W'(WAIT_CYCLES - 1)),
        .zero_o     (cnt_zero)
    );

    // WE_N and the data-bus enable are registered and only ever asserted
    // together in ACCESS, so the bus is released on the same edge as WE_N.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= SRAM_IDLE;
            op_write_q <= 1'b0;
            wdata_q    <= '0;
            addr_q     <= '0;
            rdata_q    <= '0;
            we_n_q     <= 1'b1;
            oe_q       <= 1'b0;
        end else begin
            case (state_q)
                SRAM_IDLE: begin
                    if (req) begin
                        state_q    <= SRAM_ACCESS;
                        op_write_q <= bus.wr_en;
                        wdata_q    <= bus.write_data;
                        addr_q     <= word_addr;
                        we_n_q     <= ~bus.wr_en;
                        oe_q       <= bus.wr_en;
                    end
                end
                SRAM_ACCESS: begin
                    if (cnt_zero) begin
                        state_q <= SRAM_DONE;
                        we_n_q  <= 1'b1;
                        oe_q    <= 1'b0;
                        if (!op_write_q) begin
                            rdata_q <= SRAM_DQ;
                        end
                    end
                end
                // Never re-accept here: the pipeline still holds the old request.
                SRAM_DONE: state_q <= SRAM_IDLE;
                default: begin
                    state_q <= SRAM_IDLE;
                    we_n_q  <= 1'b1;
                    oe_q    <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        ready_comb = 1'b1;
        case (state_q)
            SRAM_IDLE:   ready_comb = ~req;
            SRAM_ACCESS: ready_comb = 1'b0;
            SRAM_DONE:   ready_comb = 1'b1;
            default:     ready_comb = 1'b1;
        endcase
    end

    assign SRAM_DQ       = oe_q ? wdata_q : {DATA_W{1'bz}};
    assign SRAM_ADDR     = addr_q;
    assign SRAM_WE_N     = we_n_q;
    assign bus.read_data = rdata_q;
    assign bus.ready     = ready_comb;
endmodule
